// File: rtl/alu_seq_ctrl.sv
// Sequencer that feeds an external combinational ALU: accepts an opcode and two operand
// beats, runs one ALU cycle (or eight shift-add cycles for MUL) and holds the result.
module alu_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        cmd_valid,
  input  logic [2:0]  cmd_op,
  output logic        cmd_ready,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_op,
  input  logic [7:0]  alu_y,
  input  logic        alu_co,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        res_carry,
  output logic        res_zero,
  output logic        res_err
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_MUL = 3'd5;

  typedef enum logic [2:0] {IDLE, GET_A, GET_B, EXEC, RESP} state_t;

  state_t      state;
  logic [2:0]  op;
  logic [7:0]  opa;
  logic [7:0]  opb;     // operand B; doubles as the low product half during MUL
  logic [7:0]  hi;
  logic [2:0]  cnt;
  logic        armed;   // set once ena has been sampled after reset
  logic [15:0] mul_next;

  assign cmd_ready  = armed && ena && (state == IDLE);
  assign data_ready = ena && ((state == GET_A) || (state == GET_B));
  assign mul_next   = {alu_co, alu_y, opb[7:1]};

  always_comb begin
    alu_a  = 8'h00;
    alu_b  = 8'h00;
    alu_op = 3'd0;
    if (state == EXEC) begin
      if (op == OP_MUL) begin
        alu_a  = hi;
        alu_b  = opb[0] ? opa : 8'h00;
        alu_op = OP_ADD;
      end else begin
        alu_a  = opa;
        alu_b  = opb;
        alu_op = op;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op        <= 3'd0;
      opa       <= 8'h00;
      opb       <= 8'h00;
      hi        <= 8'h00;
      cnt       <= 3'd0;
      armed     <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= 16'h0000;
      res_carry <= 1'b0;
      res_zero  <= 1'b0;
      res_err   <= 1'b0;
    end else if (ena) begin
      armed <= 1'b1;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op <= cmd_op;
            if (cmd_op <= OP_MUL) begin
              state <= GET_A;
            end else begin
              res_valid <= 1'b1;
              res_data  <= 16'h0000;
              res_carry <= 1'b0;
              res_zero  <= 1'b1;
              res_err   <= 1'b1;
              state     <= RESP;
            end
          end
        end
        GET_A: begin
          if (data_valid) begin
            opa   <= data_in;
            state <= GET_B;
          end
        end
        GET_B: begin
          if (data_valid) begin
            opb   <= data_in;
            hi    <= 8'h00;
            cnt   <= 3'd0;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (op == OP_MUL) begin
            // {hi,lo} shifts right one bit per cycle with the ALU sum entering at the top
            {hi, opb} <= mul_next;
            cnt       <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              res_valid <= 1'b1;
              res_data  <= mul_next;
              res_carry <= 1'b0;
              res_zero  <= (mul_next == 16'h0000);
              res_err   <= 1'b0;
              state     <= RESP;
            end
          end else begin
            res_valid <= 1'b1;
            res_data  <= {8'h00, alu_y};
            res_carry <= alu_co;
            res_zero  <= (alu_y == 8'h00);
            res_err   <= 1'b0;
            state     <= RESP;
          end
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural ALU attached to the alu_* ports.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_op = 3'd0;
  logic        cmd_ready;
  logic [7:0]  data_in = 8'h00;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic [7:0]  alu_a, alu_b;
  logic [2:0]  alu_op;
  logic [7:0]  alu_y;
  logic        alu_co;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_data;
  logic        res_carry, res_zero, res_err;

  int checks = 0;
  int errors = 0;

  alu_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y), .alu_co(alu_co),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_carry(res_carry), .res_zero(res_zero), .res_err(res_err)
  );

  always #5 clk = ~clk;

  // External ALU model
  always_comb begin
    alu_y  = 8'h00;
    alu_co = 1'b0;
    case (alu_op)
      3'd0: {alu_co, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1: {alu_co, alu_y} = {1'b0, alu_a} - {1'b0, alu_b};
      3'd2: alu_y = alu_a & alu_b;
      3'd3: alu_y = alu_a | alu_b;
      3'd4: alu_y = alu_a ^ alu_b;
      default: alu_y = 8'h00;
    endcase
  end

  task automatic send_cmd(input logic [2:0] op);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] d);
    @(negedge clk);
    data_valid = 1'b1;
    data_in    = d;
    @(posedge clk);
    #1 data_valid = 1'b0;
  endtask

  // Drives a full command; lat = negedges after the B edge until res_valid is seen (20 = timeout)
  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, output int lat);
    send_cmd(op);
    send_beat(a);
    send_beat(b);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!res_valid && lat < 20);
    $display("op=%0d a=%02h b=%02h -> data=%04h carry=%0b zero=%0b err=%0b lat=%0d",
             op, a, b, res_data, res_carry, res_zero, res_err, lat);
  endtask

  task automatic pop();
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ena   = 1'b1;
    #3;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", res_valid); end
    checks++; if (res_data !== 16'h0000) begin errors++; $display("FAIL reset_data got %h exp 0000", res_data); end
    checks++; if ({res_carry, res_zero, res_err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {res_carry, res_zero, res_err}); end
    checks++; if ({cmd_ready, data_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", {cmd_ready, data_ready}); end
    checks++; if ({alu_a, alu_b, alu_op} !== 19'd0) begin errors++; $display("FAIL reset_alu got %h exp 0", {alu_a, alu_b, alu_op}); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_hold_cmd_ready got %b exp 0", cmd_ready); end
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL post_reset_cmd_ready got %b exp 1", cmd_ready); end
  endtask

  task automatic test_add();
    send_cmd(3'd0);
    send_beat(8'hF0);
    send_beat(8'h20);
    @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL add_exec_valid got %b exp 0", res_valid); end
    checks++; if ({alu_a, alu_b, alu_op} !== {8'hF0, 8'h20, 3'd0}) begin errors++; $display("FAIL add_exec_alu got %h/%h/%0d exp f0/20/0", alu_a, alu_b, alu_op); end
    @(negedge clk);
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL add_latency_valid got %b exp 1", res_valid); end
    checks++; if (res_data !== 16'h0010) begin errors++; $display("FAIL add_data got %h exp 0010", res_data); end
    checks++; if ({res_carry, res_zero, res_err} !== 3'b100) begin errors++; $display("FAIL add_flags got %b exp 100", {res_carry, res_zero, res_err}); end
    checks++; if ({alu_a, alu_b, alu_op} !== 19'd0) begin errors++; $display("FAIL add_resp_alu_idle got %h exp 0", {alu_a, alu_b, alu_op}); end
    $display("op=0 a=f0 b=20 -> data=%04h carry=%0b zero=%0b", res_data, res_carry, res_zero);
    pop();
  endtask

  task automatic test_sub();
    int lat;
    run_op(3'd1, 8'h05, 8'h05, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sub_eq_latency got %0d exp 2", lat); end
    checks++; if ({res_data, res_carry, res_zero} !== {16'h0000, 1'b0, 1'b1}) begin errors++; $display("FAIL sub_eq got %h c%b z%b exp 0000 c0 z1", res_data, res_carry, res_zero); end
    pop();
    run_op(3'd1, 8'h03, 8'h05, lat);
    checks++; if ({res_data, res_carry, res_zero} !== {16'h00FE, 1'b1, 1'b0}) begin errors++; $display("FAIL sub_borrow got %h c%b z%b exp 00fe c1 z0", res_data, res_carry, res_zero); end
    pop();
  endtask

  task automatic test_logic();
    logic [7:0] exp_tbl [3] = '{8'h30, 8'hFC, 8'hCC};
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(3'(2 + i), 8'hF0, 8'h3C, lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL logic%0d_latency got %0d exp 2", i, lat); end
      checks++; if ({res_data, res_carry} !== {8'h00, exp_tbl[i], 1'b0}) begin errors++; $display("FAIL logic%0d_data got %h c%b exp %h c0", i, res_data, res_carry, exp_tbl[i]); end
      pop();
    end
  endtask

  task automatic test_mul();
    logic [7:0]  a_tbl [3] = '{8'h00, 8'h03, 8'h0D};
    logic [7:0]  b_tbl [3] = '{8'h07, 8'h00, 8'h0B};
    logic [15:0] p_tbl [3] = '{16'h0000, 16'h0000, 16'h008F};
    int lat;
    send_cmd(3'd5);
    send_beat(8'hFF);
    send_beat(8'hFF);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      checks++; if ({res_valid, alu_op} !== 4'b0000) begin errors++; $display("FAIL mul_cycle%0d got valid %b op %0d exp 0/0", c, res_valid, alu_op); end
      if (c == 1) begin
        checks++; if ({alu_a, alu_b} !== 16'h00FF) begin errors++; $display("FAIL mul_cycle1_operands got %h/%h exp 00/ff", alu_a, alu_b); end
      end
      if (c == 2) begin
        checks++; if ({alu_a, alu_b} !== 16'h7FFF) begin errors++; $display("FAIL mul_cycle2_operands got %h/%h exp 7f/ff", alu_a, alu_b); end
      end
    end
    @(negedge clk);
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL mul_latency_valid got %b exp 1", res_valid); end
    checks++; if ({res_data, res_carry, res_zero, res_err} !== {16'hFE01, 3'b000}) begin errors++; $display("FAIL mul_ffff got %h c%b z%b e%b exp fe01 000", res_data, res_carry, res_zero, res_err); end
    $display("op=5 a=ff b=ff -> data=%04h", res_data);
    pop();
    for (int i = 0; i < 3; i++) begin
      run_op(3'd5, a_tbl[i], b_tbl[i], lat);
      checks++; if (lat !== 9) begin errors++; $display("FAIL mul%0d_latency got %0d exp 9", i, lat); end
      checks++; if ({res_data, res_zero} !== {p_tbl[i], p_tbl[i] == 16'h0000}) begin errors++; $display("FAIL mul%0d_data got %h z%b exp %h", i, res_data, res_zero, p_tbl[i]); end
      pop();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(3'd0, 8'h01, 8'h02, lat);
    data_valid = 1'b1;
    data_in    = 8'h55;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if ({res_valid, res_data, cmd_ready, data_ready} !== {1'b1, 16'h0003, 2'b00}) begin errors++; $display("FAIL hold%0d got v%b %h cr%b dr%b exp v1 0003 00", c, res_valid, res_data, cmd_ready, data_ready); end
    end
    pop();
    @(negedge clk);
    checks++; if ({res_valid, cmd_ready, data_ready} !== 3'b010) begin errors++; $display("FAIL after_pop got v%b cr%b dr%b exp 010", res_valid, cmd_ready, data_ready); end
    data_valid = 1'b0;
  endtask

  task automatic test_illegal();
    int lat;
    data_valid = 1'b1;
    data_in    = 8'hAA;
    send_cmd(3'd6);
    @(negedge clk);
    checks++; if ({res_valid, res_err, res_data, res_carry, res_zero} !== {2'b11, 16'h0000, 2'b01}) begin errors++; $display("FAIL illegal6 got v%b e%b %h c%b z%b exp 11 0000 01", res_valid, res_err, res_data, res_carry, res_zero); end
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL illegal_data_ready got %b exp 0", data_ready); end
    pop();
    @(negedge clk);
    checks++; if ({res_valid, cmd_ready} !== 2'b01) begin errors++; $display("FAIL illegal_pop got v%b cr%b exp 01", res_valid, cmd_ready); end
    data_valid = 1'b0;
    send_cmd(3'd7);
    @(negedge clk);
    checks++; if ({res_valid, res_err} !== 2'b11) begin errors++; $display("FAIL illegal7 got v%b e%b exp 11", res_valid, res_err); end
    pop();
    run_op(3'd0, 8'h80, 8'h80, lat);
    checks++; if ({res_data, res_carry, res_zero, res_err} !== {16'h0000, 3'b110}) begin errors++; $display("FAIL add_wrap got %h c%b z%b e%b exp 0000 110", res_data, res_carry, res_zero, res_err); end
    pop();
  endtask

  task automatic test_ena_freeze();
    int lat;
    send_cmd(3'd5);
    send_beat(8'h0D);
    send_beat(8'h0B);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 5) begin
        checks++; if ({cmd_ready, res_valid} !== 2'b00) begin errors++; $display("FAIL freeze_outputs got cr%b v%b exp 00", cmd_ready, res_valid); end
      end
      if (lat == 4) ena = 1'b0;
      if (lat == 7) ena = 1'b1;
    end while (!res_valid && lat < 30);
    ena = 1'b1;
    checks++; if (lat !== 12) begin errors++; $display("FAIL freeze_latency got %0d exp 12", lat); end
    checks++; if (res_data !== 16'h008F) begin errors++; $display("FAIL freeze_data got %h exp 008f", res_data); end
    $display("op=5 a=0d b=0b with 3-cycle stall -> data=%04h lat=%0d", res_data, lat);
    pop();
  endtask

  task automatic test_reset_mid();
    int lat;
    send_cmd(3'd5);
    send_beat(8'hFF);
    send_beat(8'hFF);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if ({res_valid, alu_a, alu_b, alu_op} !== 20'd0) begin errors++; $display("FAIL midreset_async got v%b alu %h/%h/%0d exp 0", res_valid, alu_a, alu_b, alu_op); end
    checks++; if ({cmd_ready, data_ready} !== 2'b00) begin errors++; $display("FAIL midreset_ready got %b exp 00", {cmd_ready, data_ready}); end
    #2 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if ({res_valid, cmd_ready} !== 2'b01) begin errors++; $display("FAIL midreset_idle got v%b cr%b exp 01", res_valid, cmd_ready); end
    run_op(3'd0, 8'h01, 8'h01, lat);
    checks++; if ({res_data, lat} !== {16'h0002, 32'd2}) begin errors++; $display("FAIL midreset_add got %h lat %0d exp 0002 lat 2", res_data, lat); end
    pop();
  endtask

  task automatic test_back_to_back();
    int lat;
    data_valid = 1'b1;
    data_in    = 8'h99;
    repeat (2) begin
      @(negedge clk);
      checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL idle_data_ready got %b exp 0", data_ready); end
    end
    data_valid = 1'b0;
    send_cmd(3'd0);
    checks++; if ({cmd_ready, data_ready} !== 2'b01) begin errors++; $display("FAIL get_a_ready got %b exp 01", {cmd_ready, data_ready}); end
    send_beat(8'h10);
    send_beat(8'h20);
    repeat (2) @(negedge clk);
    checks++; if (res_data !== 16'h0030) begin errors++; $display("FAIL b2b_first got %h exp 0030", res_data); end
    pop();
    run_op(3'd0, 8'h05, 8'h06, lat);
    checks++; if ({res_data, lat} !== {16'h000B, 32'd2}) begin errors++; $display("FAIL b2b_second got %h lat %0d exp 000b lat 2", res_data, lat); end
    pop();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_mul();
    test_backpressure();
    test_illegal();
    test_ena_freeze();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
